// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM command consumer: frame layout and
// command encodings, plus small helpers to split a frame into its fields.
package spi_ram_pkg;

    localparam int FRAME_W   = 10;
    localparam int CMD_W     = 2;
    localparam int PAYLOAD_W = 8;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    function automatic logic [CMD_W-1:0] frame_cmd(input logic [FRAME_W-1:0] frame);
        return frame[FRAME_W-1 -: CMD_W];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] frame_payload(input logic [FRAME_W-1:0] frame);
        return frame[PAYLOAD_W-1:0];
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_sp_ram.sv
// Single-port synchronous RAM: write on we_i, registered read of addr_i
// every cycle. The read port returns the contents before any same-cycle write.
module sp_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // Write port and registered read port share one address.
    // NOTE: the array has no reset; resetting a memory turns it into a huge
    // flop bank instead of a RAM macro, and the contents are undefined anyway.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command consumer behind the SPI slave. Each rising edge of rx_valid accepts
// one 10-bit frame; the top two bits select write-address, write-data,
// read-address or read-data against an on-chip RAM. Read data is returned on
// dout/tx_valid one cycle after the read is accepted and held until the next
// accepted frame.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] din,
    input  logic               rx_valid,
    output logic [DATA_W-1:0]  dout,
    output logic               tx_valid,
    output logic               seq_err
);

    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 rd_armed_q, rd_armed_d;
    logic                 seq_err_q, seq_err_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;

    logic                 accept;
    logic [CMD_W-1:0]     cmd;
    logic [PAYLOAD_W-1:0] payload;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_rdata;

    // A held rx_valid is one frame; only its rising edge is a command.
    assign accept       = rx_valid && !rx_valid_q;
    assign cmd          = frame_cmd(din);
    assign payload      = frame_payload(din);
    assign payload_addr = payload[ADDR_SIZE-1:0];

    // The RAM port serves the write address during a data write and the read
    // address otherwise, so a read-data accept samples the pre-increment rd_addr.
    assign ram_we   = accept && (cmd == CMD_WR_DATA);
    assign ram_addr = ram_we ? wr_addr_q : rd_addr_q;

    sp_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (DATA_W'(payload)),
        .rdata_o (ram_rdata)
    );

    // Next-state decode for the address registers, read sequencing and outputs.
    // NOTE: every target gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_armed_d = rd_armed_q;
        seq_err_d  = seq_err_q;
        rd_pend_d  = 1'b0;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;

        // RAM data registered on the accept edge is presented one edge later.
        if (rd_pend_q) begin
            dout_d     = ram_rdata;
            tx_valid_d = 1'b1;
        end

        if (accept) begin
            tx_valid_d = 1'b0;
            unique case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d = payload_addr;
                end
                CMD_WR_DATA: begin
                    if (AUTO_INC) begin
                        wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d  = payload_addr;
                    rd_armed_d = 1'b1;
                    seq_err_d  = 1'b0;
                end
                CMD_RD_DATA: begin
                    rd_pend_d  = 1'b1;
                    rd_armed_d = 1'b0;
                    if (AUTO_INC) begin
                        rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
                    end else if (!rd_armed_q) begin
                        seq_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // State registers; everything clears at once when rst_n drops.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_armed_q <= 1'b0;
            seq_err_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_armed_q <= rd_armed_d;
            seq_err_q  <= seq_err_d;
            rd_pend_q  <= rd_pend_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (AUTO_INC=0 and AUTO_INC=1) see the
// same frames. A frame-level reference model predicts read data into a queue
// per instance; a negedge monitor pops and compares whenever tx_valid rises.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    localparam int MEM_DEPTH = 256;

    typedef struct {
        logic [7:0] data;
        bit         known;
        int         cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [9:0]       din = '0;
    logic             rx_valid = 1'b0;
    logic [1:0][7:0]  dout_w;
    logic [1:0]       tx_w;
    logic [1:0]       serr_w;
    logic [1:0]       tx_prev = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state, one slot per instance (index 1 = auto-increment).
    logic [7:0]  m_mem   [2][MEM_DEPTH];
    bit          m_known [2][MEM_DEPTH];
    int unsigned m_wr    [2];
    int unsigned m_rd    [2];
    bit          m_armed [2];
    bit          m_serr  [2];
    logic [7:0]  m_dout  [2];
    bit          m_dout_known [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8), .AUTO_INC(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_w[0]), .tx_valid(tx_w[0]), .seq_err(serr_w[0])
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8), .AUTO_INC(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_w[1]), .tx_valid(tx_w[1]), .seq_err(serr_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a rising tx_valid must match the oldest predicted read.
    task automatic mon_pop(input int i);
        exp_t e;
        bit   empty;
        if (i == 0) begin
            empty = (q0.size() == 0);
            if (!empty) e = q0.pop_front();
        end else begin
            empty = (q1.size() == 0);
            if (!empty) e = q1.pop_front();
        end
        check($sformatf("dut%0d_tx_expected", i), 32'(empty), 32'd0);
        if (!empty) begin
            check($sformatf("dut%0d_rd_latency", i), cyc, e.cyc);
            if (e.known) check($sformatf("dut%0d_rd_data", i), dout_w[i], e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (tx_w[i] && !tx_prev[i]) mon_pop(i);
            end
            tx_prev = tx_w;
        end else begin
            tx_prev = '0;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 0;
            m_rd[i] = 0;
            m_armed[i] = 1'b0;
            m_serr[i] = 1'b0;
            m_dout[i] = 8'h00;
            m_dout_known[i] = 1'b1;
        end
        q0.delete();
        q1.delete();
    endtask

    // One accepted frame, applied at frame level to instance i.
    task automatic model_apply(input int i, input logic [1:0] cmd, input logic [7:0] pl, input int acc);
        bit   ai = (i == 1);
        exp_t e;
        case (cmd)
            CMD_WR_ADDR: m_wr[i] = pl;
            CMD_WR_DATA: begin
                m_mem[i][m_wr[i]] = pl;
                m_known[i][m_wr[i]] = 1'b1;
                if (ai) m_wr[i] = (m_wr[i] + 1) % MEM_DEPTH;
            end
            CMD_RD_ADDR: begin
                m_rd[i] = pl;
                m_armed[i] = 1'b1;
                m_serr[i] = 1'b0;
            end
            default: begin
                e.data = m_mem[i][m_rd[i]];
                e.known = m_known[i][m_rd[i]];
                e.cyc = acc + 1;
                if (i == 0) q0.push_back(e); else q1.push_back(e);
                if (!m_armed[i] && !ai) m_serr[i] = 1'b1;
                m_armed[i] = 1'b0;
                if (ai) m_rd[i] = (m_rd[i] + 1) % MEM_DEPTH;
                m_dout[i] = e.data;
                m_dout_known[i] = e.known;
            end
        endcase
    endtask

    // Called #1 after a rising edge; asserts reset, checks the cleared outputs,
    // then releases reset #1 after the following edge with rx_valid low.
    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_rst_tx", i), tx_w[i], 1'b0);
            check($sformatf("dut%0d_rst_dout", i), dout_w[i], 8'h00);
            check($sformatf("dut%0d_rst_seq_err", i), serr_w[i], 1'b0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_rst_tx_hold", i), tx_w[i], 1'b0);
            check($sformatf("dut%0d_rst_dout_hold", i), dout_w[i], 8'h00);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Accept-edge checks shared by every frame: tx_valid clears, dout holds,
    // seq_err follows the model.
    task automatic accept_checks(input logic [1:0] cmd, input logic [7:0] pl);
        int acc = cyc;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_tx_clr_on_accept", i), tx_w[i], 1'b0);
            if (m_dout_known[i]) check($sformatf("dut%0d_dout_hold", i), dout_w[i], m_dout[i]);
            model_apply(i, cmd, pl, acc);
            check($sformatf("dut%0d_seq_err", i), serr_w[i], m_serr[i]);
        end
    endtask

    // Entered #1 after a rising edge; rx_valid high for 'hold' cycles then low for 'gap'.
    task automatic send_frame(input logic [1:0] cmd, input logic [7:0] pl, input int hold, input int gap);
        din = {cmd, pl};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        accept_checks(cmd, pl);
        repeat (hold - 1) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [1:0] c;
        logic [7:0] p;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Read-data straight after reset: stale address 0, seq_err only without auto-increment.
        send_frame(CMD_RD_DATA, 8'h00, 1, 1);
        send_frame(CMD_WR_ADDR, 8'h40, 1, 1);
        send_frame(CMD_RD_ADDR, 8'h05, 1, 1);

        // Basic write then read back.
        send_frame(CMD_WR_ADDR, 8'h10, 1, 1);
        send_frame(CMD_WR_DATA, 8'hA5, 1, 1);
        send_frame(CMD_RD_ADDR, 8'h10, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 1, 2);
        // Any accept clears tx_valid while dout holds the last read.
        send_frame(CMD_WR_ADDR, 8'h20, 1, 1);

        // Held rx_valid is a single write; the neighbour keeps its value.
        send_frame(CMD_WR_ADDR, 8'h31, 1, 1);
        send_frame(CMD_WR_DATA, 8'h00, 1, 1);
        send_frame(CMD_WR_ADDR, 8'h30, 1, 1);
        send_frame(CMD_WR_DATA, 8'h3C, 12, 1);
        send_frame(CMD_RD_ADDR, 8'h30, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 3, 2);
        send_frame(CMD_RD_ADDR, 8'h31, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 1, 1);

        // Wrap-around at the top address.
        send_frame(CMD_WR_ADDR, 8'hFF, 1, 1);
        send_frame(CMD_WR_DATA, 8'h11, 1, 1);
        send_frame(CMD_WR_DATA, 8'h22, 1, 1);
        send_frame(CMD_RD_ADDR, 8'hFF, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 1, 1);

        // Reset between a read accept and its data edge drops the read.
        din = {CMD_RD_DATA, 8'h00};
        rx_valid = 1'b1;
        @(posedge clk); #1;
        do_reset();
        send_frame(CMD_WR_DATA, 8'h77, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 1, 1);
        send_frame(CMD_RD_ADDR, 8'h00, 1, 1);
        send_frame(CMD_RD_DATA, 8'h00, 2, 1);

        // Random frames; addresses confined to a window around the wrap point.
        for (int n = 0; n < 400; n++) begin
            c = 2'($urandom_range(0, 3));
            if (c == CMD_WR_DATA) p = 8'($urandom_range(0, 255));
            else p = 8'(8'hFC + $urandom_range(0, 11));
            send_frame(c, p, $urandom_range(1, 4), $urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        repeat (4) begin @(posedge clk); #1; end
        check("dut0_reads_outstanding", q0.size(), 0);
        check("dut1_reads_outstanding", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
